wb_mem_arbiter: RTL and testbench

- Three-master to one-slave Wishbone B3 arbiter in front of the external memory port (mem_* pins).
- Masters: 0 = CPU instruction bus, 1 = CPU data bus, 2 = JTAG debug master.
- Round-robin grant with bus locking for the full CYC period, so CTI/BTE incrementing bursts are never split.
- The slave side drives the memory port directly.

---
 rtl/wb_mem_arbiter_if.sv | 48 ++++
 rtl/wb_mem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_wb_mem_arbiter.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/wb_mem_arbiter_if.sv
// Wishbone bus bundle between three masters, the arbiter and the memory port.
// "slave" is the arbiter's view; "master" is the view of the surrounding fabric.
interface wb_mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [3*AW-1:0] m_adr_i;
  logic [3*DW-1:0] m_dat_i;
  logic [11:0]     m_sel_i;
  logic [2:0]      m_we_i;
  logic [2:0]      m_cyc_i;
  logic [2:0]      m_stb_i;
  logic [8:0]      m_cti_i;
  logic [5:0]      m_bte_i;
  logic [DW-1:0]   m_dat_o;
  logic [2:0]      m_ack_o;
  logic [2:0]      m_err_o;
  logic [2:0]      m_rty_o;
  logic [AW-1:0]   s_adr_o;
  logic [DW-1:0]   s_dat_o;
  logic [3:0]      s_sel_o;
  logic            s_we_o;
  logic            s_cyc_o;
  logic            s_stb_o;
  logic [2:0]      s_cti_o;
  logic [1:0]      s_bte_o;
  logic [DW-1:0]   s_dat_i;
  logic            s_ack_i;
  logic            s_err_i;
  logic            s_rty_i;
  logic [2:0]      gnt_o;

  modport slave (
    input  m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i, m_cti_i, m_bte_i,
    input  s_dat_i, s_ack_i, s_err_i, s_rty_i,
    output m_dat_o, m_ack_o, m_err_o, m_rty_o,
    output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, s_cti_o, s_bte_o,
    output gnt_o
  );

  modport master (
    output m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i, m_cti_i, m_bte_i,
    output s_dat_i, s_ack_i, s_err_i, s_rty_i,
    input  m_dat_o, m_ack_o, m_err_o, m_rty_o,
    input  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, s_cti_o, s_bte_o,
    input  gnt_o
  );
endinterface

// File: rtl/wb_mem_arbiter.sv
// 3:1 round-robin Wishbone B3 arbiter, grant locked for the whole CYC.
// Optional slave-timeout abort enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arb_lane (
  input  logic gnt,
  input  logic busy,
  input  logic s_ack,
  input  logic s_err,
  input  logic s_rty,
  input  logic to_hit,
  output logic ack,
  output logic err,
  output logic rty
);
  assign ack = s_ack & gnt & busy;
  assign err = (s_err & gnt & busy) | (to_hit & gnt);
  assign rty = s_rty & gnt & busy;
endmodule

module wb_mem_arbiter #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  wb_mem_arbiter_if.slave bus
);
  localparam int NM = 3;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("wb_mem_arbiter: TIMEOUT_CYCLES out of range 2..65535");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, ABORT = 2'd2} state_t;

  state_t          state, state_nxt;
  logic [NM-1:0]   gnt, gnt_nxt;
  logic [1:0]      last, last_nxt;
  logic [1:0]      g;
  logic            busy, resp, to_hit;
  logic [NM-1:0]   ack_v, err_v, rty_v;

  // First requester after the previous owner wins.
  function automatic logic [NM-1:0] rr_pick(input logic [NM-1:0] req, input logic [1:0] lst);
    logic [NM-1:0] r;
    logic          found;
    int            idx;
    r     = '0;
    found = 1'b0;
    for (int k = 1; k <= NM; k++) begin
      idx = (int'(lst) + k) % NM;
      if (!found && req[idx]) begin
        r[idx] = 1'b1;
        found  = 1'b1;
      end
    end
    return r;
  endfunction

  assign g    = gnt[2] ? 2'd2 : (gnt[1] ? 2'd1 : 2'd0);
  assign busy = (state == BUSY);
  assign resp = bus.s_ack_i | bus.s_err_i | bus.s_rty_i;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      gnt   <= '0;
      last  <= 2'd2;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      last  <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    last_nxt  = last;
    case (state)
      IDLE: if (|bus.m_cyc_i) begin
        gnt_nxt   = rr_pick(bus.m_cyc_i, last);
        state_nxt = BUSY;
      end
      BUSY: if (!bus.m_cyc_i[g]) begin
        last_nxt  = g;
        gnt_nxt   = '0;
        state_nxt = IDLE;
      end else if (to_hit) begin
        state_nxt = ABORT;
      end
`ifdef WB_ARB_TIMEOUT_EN
      ABORT: if (!bus.m_cyc_i[g]) begin
        last_nxt  = g;
        gnt_nxt   = '0;
        state_nxt = IDLE;
      end
`endif
      default: begin
        gnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Slave side is a pure mux of the owner; everything reads as 0 when not BUSY.
  always_comb begin
    bus.s_adr_o = '0;
    bus.s_dat_o = '0;
    bus.s_sel_o = '0;
    bus.s_we_o  = 1'b0;
    bus.s_cyc_o = 1'b0;
    bus.s_stb_o = 1'b0;
    bus.s_cti_o = '0;
    bus.s_bte_o = '0;
    if (busy) begin
      bus.s_adr_o = bus.m_adr_i[g*AW +: AW];
      bus.s_dat_o = bus.m_dat_i[g*DW +: DW];
      bus.s_sel_o = bus.m_sel_i[g*4 +: 4];
      bus.s_we_o  = bus.m_we_i[g];
      bus.s_cyc_o = bus.m_cyc_i[g];
      bus.s_stb_o = bus.m_stb_i[g];
      bus.s_cti_o = bus.m_cti_i[g*3 +: 3];
      bus.s_bte_o = bus.m_bte_i[g*2 +: 2];
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  logic [15:0] to_cnt;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || !busy || resp) to_cnt <= '0;
    else if (bus.s_stb_o)          to_cnt <= to_cnt + 16'd1;
  end

  // Fires on the TIMEOUT_CYCLES-th consecutive unanswered strobe cycle.
  assign to_hit = busy && bus.s_cyc_o && bus.s_stb_o && !resp &&
                  (to_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
  assign to_hit = 1'b0;
`endif

  wb_arb_lane u_lane [NM-1:0] (
    .gnt    (gnt),
    .busy   (busy),
    .s_ack  (bus.s_ack_i),
    .s_err  (bus.s_err_i),
    .s_rty  (bus.s_rty_i),
    .to_hit (to_hit),
    .ack    (ack_v),
    .err    (err_v),
    .rty    (rty_v)
  );

  assign bus.m_ack_o = ack_v;
  assign bus.m_err_o = err_v;
  assign bus.m_rty_o = rty_v;
  assign bus.m_dat_o = bus.s_dat_i;
  assign bus.gnt_o   = gnt;
endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed bench for wb_mem_arbiter: grant order, burst lock, reset, retry, timeout.
module tb_wb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic [2:0] seen;

  always #5 clk = ~clk;

  wb_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  wb_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(8)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_m(input int n, input logic cyc, input logic we,
                       input logic [31:0] adr, input logic [2:0] cti);
    bus.m_cyc_i[n]         = cyc;
    bus.m_stb_i[n]         = cyc;
    bus.m_we_i[n]          = we;
    bus.m_adr_i[n*AW +: AW] = adr;
    bus.m_dat_i[n*DW +: DW] = adr ^ 32'hA5A5_0000;
    bus.m_sel_i[n*4 +: 4]  = 4'hF;
    bus.m_cti_i[n*3 +: 3]  = cti;
    bus.m_bte_i[n*2 +: 2]  = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.m_adr_i = '0; bus.m_dat_i = '0; bus.m_sel_i = '0; bus.m_we_i = '0;
    bus.m_cyc_i = '0; bus.m_stb_i = '0; bus.m_cti_i = '0; bus.m_bte_i = '0;
    bus.s_dat_i = '0; bus.s_ack_i = 1'b0; bus.s_err_i = 1'b0; bus.s_rty_i = 1'b0;

    // reset state
    tick(); tick();
    chk("rst_gnt", 32'(bus.gnt_o), 32'd0);
    chk("rst_scyc", 32'(bus.s_cyc_o), 32'd0);
    chk("rst_sadr", bus.s_adr_o, 32'd0);
    chk("rst_ack", 32'(bus.m_ack_o), 32'd0);
    rst = 1'b0;

    // single read by master 1, slave acks two cycles after STB
    tick();
    set_m(1, 1'b1, 1'b0, 32'h0000_0400, 3'b000);
    #1 chk("t1_cyc_pre", 32'(bus.s_cyc_o), 32'd0);
    tick();
    chk("t1_gnt", 32'(bus.gnt_o), 32'b010);
    chk("t1_cyc", 32'(bus.s_cyc_o), 32'd1);
    chk("t1_adr", bus.s_adr_o, 32'h0000_0400);
    chk("t1_ack_c0", 32'(bus.m_ack_o), 32'd0);
    tick();
    chk("t1_ack_c1", 32'(bus.m_ack_o), 32'd0);
    tick();
    bus.s_ack_i = 1'b1; bus.s_dat_i = 32'hDEAD_BEEF;
    #1 chk("t1_ack", 32'(bus.m_ack_o), 32'b010);
    chk("t1_dat", bus.m_dat_o, 32'hDEAD_BEEF);
    tick();
    bus.s_ack_i = 1'b0;
    set_m(1, 1'b0, 1'b0, 32'h0, 3'b000);
    #1 chk("t1_ack_off", 32'(bus.m_ack_o), 32'd0);
    tick();
    chk("t1_release", 32'(bus.gnt_o), 32'd0);

    // all three request right after reset release: order 0,1,2
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) set_m(k, 1'b1, 1'b0, 32'h1000 * (k + 1), 3'b000);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t2_gnt", 32'(bus.gnt_o), 32'(1 << k));
      chk("t2_adr", bus.s_adr_o, 32'h1000 * (k + 1));
      bus.s_ack_i = 1'b1;
      #1 chk("t2_ack", 32'(bus.m_ack_o), 32'(1 << k));
      tick();
      bus.s_ack_i = 1'b0;
      set_m(k, 1'b0, 1'b0, 32'h0, 3'b000);
      tick();
      chk("t2_gap", 32'(bus.gnt_o), 32'd0);
    end

    // 4-beat burst by master 0 while master 2 waits
    set_m(0, 1'b1, 1'b0, 32'h100, 3'b010);
    set_m(2, 1'b1, 1'b1, 32'h200, 3'b000);
    tick();
    chk("t3_gnt0", 32'(bus.gnt_o), 32'b001);
    for (int b = 0; b < 4; b++) begin
      set_m(0, 1'b1, 1'b0, 32'h100 + 32'(4 * b), (b == 3) ? 3'b111 : 3'b010);
      bus.s_ack_i = 1'b1;
      #1 chk("t3_ack", 32'(bus.m_ack_o), 32'b001);
      chk("t3_cti", 32'(bus.s_cti_o), (b == 3) ? 32'b111 : 32'b010);
      chk("t3_adr", bus.s_adr_o, 32'h100 + 32'(4 * b));
      tick();
    end
    bus.s_ack_i = 1'b0;
    set_m(0, 1'b0, 1'b0, 32'h0, 3'b000);
    #1 chk("t3_hold", 32'(bus.gnt_o), 32'b001);
    tick();
    chk("t3_gap", 32'(bus.gnt_o), 32'd0);
    tick();
    chk("t3_gnt2", 32'(bus.gnt_o), 32'b100);
    chk("t3_we2", 32'(bus.s_we_o), 32'd1);
    chk("t3_adr2", bus.s_adr_o, 32'h200);

    // retry to master 2, grant kept while its CYC stays high
    bus.s_rty_i = 1'b1;
    #1 chk("t6_rty", 32'(bus.m_rty_o), 32'b100);
    chk("t6_noack", 32'(bus.m_ack_o), 32'd0);
    tick();
    bus.s_rty_i = 1'b0;
    #1 chk("t6_rty_off", 32'(bus.m_rty_o), 32'd0);
    tick();
    chk("t6_keep", 32'(bus.gnt_o), 32'b100);
    chk("t6_cyc", 32'(bus.s_cyc_o), 32'd1);
    set_m(2, 1'b0, 1'b0, 32'h0, 3'b000);
    tick();
    chk("t6_release", 32'(bus.gnt_o), 32'd0);

    // reset in the middle of a master 1 burst
    set_m(1, 1'b1, 1'b0, 32'h300, 3'b010);
    tick();
    chk("t4_gnt", 32'(bus.gnt_o), 32'b010);
    bus.s_ack_i = 1'b1;
    #1 chk("t4_ack", 32'(bus.m_ack_o), 32'b010);
    tick();
    rst = 1'b1;
    tick();
    chk("t4_rst_gnt", 32'(bus.gnt_o), 32'd0);
    chk("t4_rst_cyc", 32'(bus.s_cyc_o), 32'd0);
    chk("t4_rst_ack", 32'(bus.m_ack_o), 32'd0);
    rst = 1'b0;
    bus.s_ack_i = 1'b0;
    set_m(2, 1'b1, 1'b0, 32'h400, 3'b000);
    tick();
    chk("t4_regnt", 32'(bus.gnt_o), 32'b010);
    set_m(1, 1'b0, 1'b0, 32'h0, 3'b000);
    tick();
    tick();
    chk("t4_next", 32'(bus.gnt_o), 32'b100);
    set_m(2, 1'b0, 1'b0, 32'h0, 3'b000);
    tick();
    tick();

    // slave never answers master 1
    set_m(1, 1'b1, 1'b0, 32'h500, 3'b000);
    tick();
    chk("t5_gnt", 32'(bus.gnt_o), 32'b010);
`ifdef WB_ARB_TIMEOUT_EN
    for (int i = 1; i < 8; i++) begin
      chk("t5_err_early", 32'(bus.m_err_o), 32'd0);
      tick();
    end
    chk("t5_err", 32'(bus.m_err_o), 32'b010);
    tick();
    chk("t5_err_once", 32'(bus.m_err_o), 32'd0);
    chk("t5_abort_cyc", 32'(bus.s_cyc_o), 32'd0);
    chk("t5_abort_gnt", 32'(bus.gnt_o), 32'b010);
    bus.s_ack_i = 1'b1;
    #1 chk("t5_late_ack", 32'(bus.m_ack_o), 32'd0);
    tick();
    bus.s_ack_i = 1'b0;
    chk("t5_abort_cyc2", 32'(bus.s_cyc_o), 32'd0);
`else
    seen = '0;
    repeat (1000) begin
      seen = seen | bus.m_err_o;
      tick();
    end
    chk("t5_no_err", 32'(seen), 32'd0);
    chk("t5_hung_cyc", 32'(bus.s_cyc_o), 32'd1);
    chk("t5_hung_gnt", 32'(bus.gnt_o), 32'b010);
`endif
    set_m(1, 1'b0, 1'b0, 32'h0, 3'b000);
    tick();
    chk("t5_release", 32'(bus.gnt_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
